// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, destination select and 32-cycle shift-add multiplier.
// Define EX_FWD_EN to enable EX-to-EX forwarding (adds the rs_in port).
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0]   inst1_in,
    input  logic [REG_AW-1:0]   inst2_in,
    input  logic [REG_AW-1:0]   inst3_in,
`ifdef EX_FWD_EN
    input  logic [REG_AW-1:0]   rs_in,
`endif
    input  logic [5:0]          excntrlsig_in,
    input  logic [3:0]          memcntrlsig_in,
    input  logic [1:0]          wbcntrlsig_in,
    input  logic [DATA_W-1:0]   addr_in,
    output logic                stall_out,
    output logic [DATA_W-1:0]   alu_result_out,
    output logic [DATA_W-1:0]   write_data_out,
    output logic [REG_AW-1:0]   dest_reg_out,
    output logic                zero_out,
    output logic [3:0]          memcntrlsig_out,
    output logic [1:0]          wbcntrlsig_out,
    output logic [DATA_W-1:0]   addr_out
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic [DATA_W-1:0] r_mcand, r_mplier, r_acc;
    logic [CW-1:0] r_cnt;
    logic [DATA_W-1:0] w_rs, w_rt, w_b, w_alu, w_res;
    logic [REG_AW-1:0] w_dest;
    logic w_alusrc, w_is_mul, w_bubble, w_done;
    logic [2:0] w_op;
    logic [1:0] w_regdst;
    assign {w_alusrc, w_op, w_regdst} = excntrlsig_in;
`ifdef EX_FWD_EN
    logic w_fwd;
    assign w_fwd = wbcntrlsig_out[1] && !memcntrlsig_out[3] && dest_reg_out != '0;
    assign w_rs = (w_fwd && dest_reg_out == rs_in) ? alu_result_out : read_data_in[DATA_W-1:0];
    assign w_rt = (w_fwd && dest_reg_out == inst2_in) ? alu_result_out : read_data_in[2*DATA_W-1:DATA_W];
`else
    assign w_rs = read_data_in[DATA_W-1:0];
    assign w_rt = read_data_in[2*DATA_W-1:DATA_W];
`endif
    assign w_b = w_alusrc ? inst1_in : w_rt;
    assign w_is_mul = w_op == 3'b101;
    assign w_done = r_state == DONE;
    assign w_bubble = (r_state == BUSY) || (r_state == IDLE && w_is_mul);
    assign w_dest = w_regdst == 2'b01 ? inst3_in : w_regdst == 2'b10 ? REG_AW'(31) : inst2_in;
    assign w_res = w_regdst == 2'b10 ? addr_in : w_alu;
    always_comb begin
        w_alu = '0;
        case (w_op)
            3'b000:  w_alu = w_rs + w_b;
            3'b001:  w_alu = w_rs - w_b;
            3'b010:  w_alu = w_rs & w_b;
            3'b011:  w_alu = w_rs | w_b;
            3'b100:  w_alu = {{(DATA_W-1){1'b0}}, $signed(w_rs) < $signed(w_b)};
            3'b110:  w_alu = w_rs ^ w_b;
            3'b111:  w_alu = ~(w_rs | w_b);
            default: w_alu = '0;
        endcase
    end
    always_comb begin
        w_next = r_state;
        stall_out = 1'b0;
        case (r_state)
            IDLE: begin
                stall_out = w_is_mul && !rst;
                w_next = w_is_mul ? BUSY : IDLE;
            end
            BUSY: begin
                stall_out = !rst;
                w_next = r_cnt == CW'(DATA_W-1) ? DONE : BUSY;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_acc <= '0;
            r_mcand <= '0;
            r_mplier <= '0;
            alu_result_out <= '0;
            write_data_out <= '0;
            dest_reg_out <= '0;
            zero_out <= 1'b0;
            memcntrlsig_out <= '0;
            wbcntrlsig_out <= '0;
            addr_out <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_is_mul) begin
                r_mcand <= w_rs;
                r_mplier <= w_b;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == BUSY) begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt <= r_cnt + CW'(1);
            end
            alu_result_out <= w_bubble ? '0 : w_done ? r_acc : w_res;
            zero_out <= !w_bubble && (w_done ? r_acc == '0 : w_alu == '0);
            write_data_out <= w_bubble ? '0 : w_rt;
            dest_reg_out <= w_bubble ? '0 : w_dest;
            memcntrlsig_out <= w_bubble ? '0 : memcntrlsig_in;
            wbcntrlsig_out <= w_bubble ? '0 : wbcntrlsig_in;
            addr_out <= w_bubble ? '0 : addr_in;
        end
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Computes the ALU result, selects the destination register, and registers everything into the EX/MEM boundary.
- Adds an iterative 32-cycle shift-add multiplier. While a multiply runs, the block stalls upstream stages and inserts bubbles downstream.

Parameters:
- DATA_W, 32, operand/result width; multiply iteration count equals DATA_W
- REG_AW, 5, register-address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- read_data_in  in  64  [31:0] rs data, [63:32] rt data
- inst1_in  in  32  sign-extended immediate
- inst2_in  in  5  rt field
- inst3_in  in  5  rd field
- excntrlsig_in  in  6  {ALUSrc, ALUOp[2:0], RegDst[1:0]}
- memcntrlsig_in  in  4  {MemRead, MemWrite, PCSrc[1:0]}
- wbcntrlsig_in  in  2  {RegWrite, MemToReg}
- addr_in  in  32  PC+4 of the instruction
- stall_out  out  1  upstream must hold PC, IF/ID and ID/EX while high
- alu_result_out  out  32  registered result
- write_data_out  out  32  registered rt data (store data)
- dest_reg_out  out  5  registered destination register
- zero_out  out  1  registered (ALU result == 0)
- memcntrlsig_out  out  4  registered MEM controls
- wbcntrlsig_out  out  2  registered WB controls
- addr_out  out  32  registered PC+4

Behaviour:
- Reset is asynchronous and active-high. All outputs become 0, the FSM goes to IDLE, and the iteration counter clears.
- Operand A is rs data. Operand B is inst1_in when ALUSrc=1, otherwise rt data.
- ALUOp encoding:
  - 000 add, 001 sub, 010 and, 011 or
  - 100 slt (signed, result 0 or 1), 101 mul (low 32 bits of A*B)
  - 110 xor, 111 nor
- Add and sub wrap modulo 2^32. There is no overflow trap.
- RegDst encoding: 00 rt, 01 rd, 10 register 31, 11 rt.
- When RegDst=10, alu_result_out takes addr_in (link value) instead of the ALU result.
- Non-mul ops have 1-cycle latency. Inputs present in cycle N appear on the outputs after edge N+1.
- FSM states IDLE, BUSY, DONE:
  - IDLE, ALUOp!=101: register the normal result. Stay in IDLE. stall_out=0.
  - IDLE, ALUOp==101: stall_out=1 combinationally. Load the multiplicand and multiplier, clear the accumulator and counter. Register a bubble (mem/wb controls 0; other outputs 0). Go to BUSY.
  - BUSY: stall_out=1. Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; increment the counter. Register a bubble. When the counter reaches DATA_W-1, go to DONE.
  - DONE: stall_out=0. Register the accumulator together with the held instruction's dest/controls/addr. zero_out follows the accumulator. Go to IDLE unconditionally; the held mul is never re-issued.
- Multiply timing:
  - stall_out is high for DATA_W+1 consecutive cycles.
  - The result appears after DATA_W+2 edges from first presentation.
- A mul with RegWrite=0 still runs the full sequence.
- Inputs are held by upstream for the whole stall. The block samples instruction fields in DONE, not from a private copy. Operand values are captured at the IDLE-to-BUSY transition only.
- Reset mid-multiply aborts immediately: IDLE, stall_out=0, all outputs 0.
- An all-zero control word (bubble from the hazard unit) is treated as an add with no side effects.

Optional Feature:
- Macro: EX_FWD_EN
- Defined (EX-to-EX forwarding):
  - If wbcntrlsig_out[1]=1, memcntrlsig_out[3]=0 and dest_reg_out!=0, forwarding applies per operand.
  - dest_reg_out equal to the rs field replaces rs data with alu_result_out.
  - dest_reg_out equal to the rt field replaces rt data with alu_result_out. This covers both operand B when ALUSrc=0 and write data.
  - This requires extra inputs rs_in[4:0] (rs field), present only when the macro is defined.
- Not defined: operands come straight from read_data_in. The hazard unit inserts NOPs instead.

Test Plan:
- Reset: rst=1 for 2 cycles mid-operation -> all outputs 0, stall_out 0.
- Add: rs=5, rt=7, ALUSrc=0, ALUOp=000, RegDst=01, rd=9, wb=10 -> next edge: alu_result_out=12, dest_reg_out=9, zero_out=0, wbcntrlsig_out=10.
- Sub, slt and link:
  - rs=rt=0x1234, sub -> alu_result_out=0, zero_out=1.
  - rs=0xFFFFFFFF, rt=1, slt -> result 1.
  - RegDst=10, addr_in=0x40 -> alu_result_out=0x40, dest 31.
- Mul: rs=0x0001_0003, rt=0x0000_0005 -> stall_out high 33 cycles, 33 bubbles on the outputs, then alu_result_out=0x0005_000F.
- Mul, then reset asserted at BUSY cycle 10 -> outputs 0 and stall_out 0 immediately. The next add executes normally.
- With EX_FWD_EN: add writes r3=10, next instruction add r4=r3+r3 with stale read_data 0 -> alu_result_out=20. Without the macro -> 0.
